wb_stage: RTL and testbench

Writeback stage of the 5-stage MIPS pipeline. Consumes the MEM/WB segment register outputs and produces the GPR write port and debug trace:
- formats load data (byte/half/word, signed/unsigned, LWL/LWR),
- selects the writeback source,
- owns the architectural HI/LO registers.

It also exposes a WB-stage forwarding source for decode and keeps a retired-instruction counter.

---
 rtl/mips_defs.sv | 19 +
 rtl/wb_stage_load_fmt.sv | 51 +++++
 rtl/wb_stage.sv | 91 +++++++++
 tb/tb_wb_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: load opcodes and the bit layout of the
// wreg / rhilo / whilo control fields carried down the pipe.
package mips_defs;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  localparam int WREG_NGPR = 5;  // wreg[5]: target is not a GPR
  localparam int RHILO_HI  = 1;  // MFHI
  localparam int RHILO_LO  = 0;  // MFLO
  localparam int WHILO_HI  = 1;
  localparam int WHILO_LO  = 0;

endpackage

// File: rtl/wb_stage_load_fmt.sv
// Load data formatter: extracts and extends byte/half loads and merges the
// unaligned LWL/LWR word with the current rt value. Purely combinational.
module load_fmt
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_data,
  output logic [31:0] data,
  output logic [3:0]  strb
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [31:0] lwl_data;
  logic [31:0] lwr_data;

  // Little-endian: byte k lives at bits [8k+7:8k]; 3-k is simply ~k.
  assign lwl_sh   = {~off, 3'b000};
  assign lwr_sh   = {off, 3'b000};
  assign byte_sel = 8'(rdata >> lwr_sh);
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  assign lwl_data = (rdata << lwl_sh) | (rt_data & ~(32'hFFFF_FFFF << lwl_sh));
  assign lwr_data = (rdata >> lwr_sh) | (rt_data & ~(32'hFFFF_FFFF >> lwr_sh));

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    data = rdata;
    strb = 4'b1111;
    case (op)
      OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: data = {24'h0, byte_sel};
      OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      OP_LHU: data = {16'h0, half_sel};
      OP_LWL: begin
        data = lwl_data;
        strb = 4'b1111 << ~off;
      end
      OP_LWR: begin
        data = lwr_data;
        strb = 4'b1111 >> off;
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: selects GPR write data, formats loads, owns the
// architectural HI/LO registers and counts retired instructions.
module wb_stage
  import mips_defs::*;
#(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_inst,
  input  logic [31:0]      wb_res,
  input  logic [31:0]      wb_hi,
  input  logic [31:0]      wb_lo,
  input  logic [31:0]      wb_rdata,
  input  logic [31:0]      wb_rt_data,
  input  logic             wb_load,
  input  logic             wb_al,
  input  logic             wb_regwen,
  input  logic [5:0]       wb_wreg,
  input  logic [1:0]       wb_rhilo,
  input  logic [1:0]       wb_whilo,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [31:0]      fwd_data,
  output logic [31:0]      hi_q,
  output logic [31:0]      lo_q,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retired
);

  logic [31:0] load_data;
  logic [3:0]  load_strb;

  load_fmt u_load_fmt (
    .op      (wb_inst[31:26]),
    .off     (wb_res[1:0]),
    .rdata   (wb_rdata),
    .rt_data (wb_rt_data),
    .data    (load_data),
    .strb    (load_strb)
  );

  assign rf_wen   = wb_regwen & ~wb_wreg[WREG_NGPR] & (wb_wreg[4:0] != 5'd0);
  assign rf_waddr = wb_wreg[4:0];

  always_comb begin
    rf_wdata = wb_res;
    if (wb_rhilo[RHILO_HI])      rf_wdata = hi_q;
    else if (wb_rhilo[RHILO_LO]) rf_wdata = lo_q;
    else if (wb_al)              rf_wdata = wb_pc + 32'd8;
    else if (wb_load)            rf_wdata = load_data;
  end

  always_comb begin
    debug_wb_rf_wen = 4'b1111;
    if (!rf_wen)      debug_wb_rf_wen = 4'b0000;
    else if (wb_load) debug_wb_rf_wen = load_strb;
  end

  assign fwd_valid         = rf_wen;
  assign fwd_data          = rf_wdata;
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // A same-cycle MFHI/MFLO sees the value before this edge's write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled
    // on the clock edge, so it has no place in the sensitivity list.
    if (!resetn) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else begin
      if (wb_whilo[WHILO_HI]) hi_q <= wb_hi;
      if (wb_whilo[WHILO_LO]) lo_q <= wb_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)              retired <= '0;
    else if (wb_pc != 32'd0)  retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a table of combinational writeback
// vectors plus directed sequences for HI/LO timing and the retire counter.
module tb_wb_stage;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] wb_pc, wb_inst, wb_res, wb_hi, wb_lo, wb_rdata, wb_rt_data;
  logic        wb_load, wb_al, wb_regwen;
  logic [5:0]  wb_wreg;
  logic [1:0]  wb_rhilo, wb_whilo;
  logic        rf_wen, fwd_valid;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, fwd_data, hi_q, lo_q, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32), .HILO_RST(32'h0)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_pc             (wb_pc),
    .wb_inst           (wb_inst),
    .wb_res            (wb_res),
    .wb_hi             (wb_hi),
    .wb_lo             (wb_lo),
    .wb_rdata          (wb_rdata),
    .wb_rt_data        (wb_rt_data),
    .wb_load           (wb_load),
    .wb_al             (wb_al),
    .wb_regwen         (wb_regwen),
    .wb_wreg           (wb_wreg),
    .wb_rhilo          (wb_rhilo),
    .wb_whilo          (wb_whilo),
    .rf_wen            (rf_wen),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_valid         (fwd_valid),
    .fwd_data          (fwd_data),
    .hi_q              (hi_q),
    .lo_q              (lo_q),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retired           (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] pc, res, rdata, rt;
    logic        load, al, regwen;
    logic [5:0]  wreg;
    logic [1:0]  rhilo;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[$];

  task automatic idle();
    wb_pc = 0; wb_inst = 0; wb_res = 0; wb_hi = 0; wb_lo = 0;
    wb_rdata = 0; wb_rt_data = 0; wb_load = 0; wb_al = 0; wb_regwen = 0;
    wb_wreg = 0; wb_rhilo = 0; wb_whilo = 0;
  endtask

  task automatic step(input logic [31:0] pc);
    wb_pc = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic [5:0] op, input logic [31:0] pc,
                     input logic [31:0] res, input logic [31:0] rdata, input logic [31:0] rt,
                     input logic load, input logic al, input logic regwen,
                     input logic [5:0] wreg, input logic [1:0] rhilo,
                     input logic wen, input logic [31:0] wdata, input logic [3:0] strb);
    vec_t v;
    v.name = n; v.op = op; v.pc = pc; v.res = res; v.rdata = rdata; v.rt = rt;
    v.load = load; v.al = al; v.regwen = regwen; v.wreg = wreg; v.rhilo = rhilo;
    v.exp_wen = wen; v.exp_wdata = wdata; v.exp_strb = strb;
    vecs.push_back(v);
  endtask

  initial begin
    // name   op      pc            res           rdata         rt            ld al rw wreg   rhilo wen wdata         strb
    add("lb",   OP_LB,  32'h0,        32'h1000_0002, 32'h1182_3344, 32'h0,        1, 0, 1, 6'd3,  2'b00, 1, 32'hFFFF_FF82, 4'hF);
    add("lbu",  OP_LBU, 32'h0,        32'h1000_0002, 32'h1182_3344, 32'h0,        1, 0, 1, 6'd3,  2'b00, 1, 32'h0000_0082, 4'hF);
    add("lh",   OP_LH,  32'h0,        32'h1000_0002, 32'h8001_1234, 32'h0,        1, 0, 1, 6'd4,  2'b00, 1, 32'hFFFF_8001, 4'hF);
    add("lhu",  OP_LHU, 32'h0,        32'h1000_0003, 32'h8001_1234, 32'h0,        1, 0, 1, 6'd4,  2'b00, 1, 32'h0000_8001, 4'hF);
    add("lwl1", OP_LWL, 32'h0,        32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 1, 6'd5,  2'b00, 1, 32'hCCDD_3344, 4'b1100);
    add("lwr1", OP_LWR, 32'h0,        32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 1, 6'd5,  2'b00, 1, 32'h11AA_BBCC, 4'b0111);
    add("lwl0", OP_LWL, 32'h0,        32'h1000_0000, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 1, 6'd5,  2'b00, 1, 32'hDD22_3344, 4'b1000);
    add("lwl3", OP_LWL, 32'h0,        32'h1000_0003, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 1, 6'd5,  2'b00, 1, 32'hAABB_CCDD, 4'b1111);
    add("lwr0", OP_LWR, 32'h0,        32'h1000_0000, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 1, 6'd5,  2'b00, 1, 32'hAABB_CCDD, 4'b1111);
    add("lwr3", OP_LWR, 32'h0,        32'h1000_0003, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 1, 6'd5,  2'b00, 1, 32'h1122_33AA, 4'b0001);
    add("lw",   OP_LW,  32'h0,        32'h1000_0000, 32'hDEAD_BEEF, 32'h0,        1, 0, 1, 6'd6,  2'b00, 1, 32'hDEAD_BEEF, 4'hF);
    add("r0",   6'd0,   32'h0,        32'h1234_5678, 32'h0,        32'h0,        0, 0, 1, 6'h00, 2'b00, 0, 32'h1234_5678, 4'h0);
    add("ngpr", 6'd0,   32'h0,        32'h1234_5678, 32'h0,        32'h0,        0, 0, 1, 6'h21, 2'b00, 0, 32'h1234_5678, 4'h0);
    add("link", 6'd3,   32'hBFC0_0010, 32'h0,        32'h0,        32'h0,        0, 1, 1, 6'd31, 2'b00, 1, 32'hBFC0_0018, 4'hF);
    add("alu",  6'd0,   32'h0,        32'h1234_5678, 32'h0,        32'h0,        0, 0, 1, 6'd7,  2'b00, 1, 32'h1234_5678, 4'hF);
    add("nowen",6'd0,   32'h0,        32'h1234_5678, 32'h0,        32'h0,        0, 0, 0, 6'd7,  2'b00, 0, 32'h1234_5678, 4'h0);
  end

  initial begin
    idle();
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_hi", hi_q, 32'h0);
    check("rst_lo", lo_q, 32'h0);
    check("rst_retired", retired, 32'h0);
    resetn = 1'b1;

    // Retire counter: 3 valid, 2 bubbles, 1 valid
    step(32'hBFC0_0000);
    step(32'hBFC0_0004);
    step(32'hBFC0_0008);
    step(32'h0);
    step(32'h0);
    step(32'hBFC0_000C);
    wb_pc = 32'h0;
    check("retired_4", retired, 32'd4);

    // HI/LO write and same-cycle read of the old value
    wb_whilo = 2'b11; wb_hi = 32'd5; wb_lo = 32'd7;
    wb_rhilo = 2'b10; wb_regwen = 1'b1; wb_wreg = 6'd2;
    #1;
    check("mfhi_old", rf_wdata, 32'h0);
    @(posedge clk); #1;
    wb_whilo = 2'b00; wb_hi = 32'd9; wb_lo = 32'd9;
    #1;
    check("mfhi_new", rf_wdata, 32'd5);
    check("hi_q", hi_q, 32'd5);
    check("lo_q", lo_q, 32'd7);
    wb_rhilo = 2'b01; wb_al = 1'b1; wb_pc = 32'hBFC0_0010;
    #1;
    check("mflo_over_al", rf_wdata, 32'd7);
    @(posedge clk); #1;
    check("hi_hold", hi_q, 32'd5);
    check("retired_5", retired, 32'd5);

    // Table of combinational vectors
    for (int i = 0; i < vecs.size(); i++) begin
      idle();
      wb_inst = {vecs[i].op, 26'h0};
      wb_pc = vecs[i].pc; wb_res = vecs[i].res; wb_rdata = vecs[i].rdata;
      wb_rt_data = vecs[i].rt; wb_load = vecs[i].load; wb_al = vecs[i].al;
      wb_regwen = vecs[i].regwen; wb_wreg = vecs[i].wreg; wb_rhilo = vecs[i].rhilo;
      @(negedge clk);
      check({vecs[i].name, "_wen"}, {31'h0, rf_wen}, {31'h0, vecs[i].exp_wen});
      check({vecs[i].name, "_waddr"}, {27'h0, rf_waddr}, {27'h0, vecs[i].wreg[4:0]});
      check({vecs[i].name, "_wdata"}, rf_wdata, vecs[i].exp_wdata);
      check({vecs[i].name, "_strb"}, {28'h0, debug_wb_rf_wen}, {28'h0, vecs[i].exp_strb});
      check({vecs[i].name, "_fwd_v"}, {31'h0, fwd_valid}, {31'h0, vecs[i].exp_wen});
      check({vecs[i].name, "_fwd_d"}, fwd_data, vecs[i].exp_wdata);
      check({vecs[i].name, "_dbg_d"}, debug_wb_rf_wdata, vecs[i].exp_wdata);
      check({vecs[i].name, "_dbg_n"}, {27'h0, debug_wb_rf_wnum}, {27'h0, vecs[i].wreg[4:0]});
      check({vecs[i].name, "_dbg_pc"}, debug_wb_pc, vecs[i].pc);
    end

    // Mid-run reset with a valid instruction present: increment suppressed
    idle();
    wb_pc = 32'hBFC0_0020;
    wb_whilo = 2'b11; wb_hi = 32'hFFFF_FFFF; wb_lo = 32'hFFFF_FFFF;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst2_retired", retired, 32'h0);
    check("rst2_hi", hi_q, 32'h0);
    check("rst2_lo", lo_q, 32'h0);
    resetn = 1'b1;
    idle();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
